// File: rtl/rx_cmd_decoder_if.sv
// Byte stream from the UART receiver into the command decoder, plus the
// decoded rate/status/error outputs going back out to the control logic.
interface rx_cmd_decoder_if;
   logic [7:0] rxData;
   logic       rxValid;
   logic [1:0] rate;
   logic       rateUpdate;
   logic       statusReq;
   logic       cmdErr;
   logic       busy;

   modport master (
      output rxData, rxValid,
      input  rate, rateUpdate, statusReq, cmdErr, busy
   );

   modport slave (
      input  rxData, rxValid,
      output rate, rateUpdate, statusReq, cmdErr, busy
   );
endinterface

// File: rtl/rx_cmd_decoder.sv
// Parses LF-terminated "rate:<1|5|a>" and "state" command lines from the UART
// receive byte stream and turns them into rate updates or status requests.
module rx_cmd_decoder #(
   parameter int TIMEOUT_CYCLES = 50_000_000
) (
   input  logic             clk,
   input  logic             reset,
   rx_cmd_decoder_if.slave  bus
);

   typedef enum logic [2:0] {IDLE, M_RATE, ARG, M_STATE, WAIT_LF, DISCARD} stateT;

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] TLIMIT = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [7:0] LF = 8'h0A;
   localparam logic [7:0] CR = 8'h0D;

   stateT         state;
   logic [2:0]    idx;
   logic [1:0]    pendRate;
   logic          pendStatus;
   logic [CW-1:0] timer;

   // Keyword characters still expected after the leading 'r' or 's'.
   function automatic logic [7:0] rateChar(input logic [2:0] i);
      case (i)
         3'd1:    return "a";
         3'd2:    return "t";
         3'd3:    return "e";
         3'd4:    return ":";
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [7:0] stateChar(input logic [2:0] i);
      case (i)
         3'd1:    return "t";
         3'd2:    return "a";
         3'd3:    return "t";
         3'd4:    return "e";
         default: return 8'h00;
      endcase
   endfunction

   assign bus.busy = (state != IDLE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state          <= IDLE;
         idx            <= 3'd0;
         pendRate       <= 2'b00;
         pendStatus     <= 1'b0;
         timer          <= '0;
         bus.rate       <= 2'b00;
         bus.rateUpdate <= 1'b0;
         bus.statusReq  <= 1'b0;
         bus.cmdErr     <= 1'b0;
      end else begin
         bus.rateUpdate <= 1'b0;
         bus.statusReq  <= 1'b0;
         bus.cmdErr     <= 1'b0;
         if (bus.rxValid) begin
            timer <= '0;
            // CR is transparent everywhere so CRLF line endings just work.
            if (bus.rxData != CR) begin
               case (state)
                  IDLE: begin
                     if (bus.rxData == "r") begin
                        state <= M_RATE;
                        idx   <= 3'd1;
                     end else if (bus.rxData == "s") begin
                        state <= M_STATE;
                        idx   <= 3'd1;
                     end else if (bus.rxData != LF) begin
                        state <= DISCARD;
                     end
                  end
                  M_RATE: begin
                     if (bus.rxData == LF) begin
                        bus.cmdErr <= 1'b1;
                        state      <= IDLE;
                        idx        <= 3'd0;
                     end else if (bus.rxData == rateChar(idx)) begin
                        if (idx == 3'd4) begin
                           state <= ARG;
                           idx   <= 3'd0;
                        end else begin
                           idx <= idx + 3'd1;
                        end
                     end else begin
                        state <= DISCARD;
                        idx   <= 3'd0;
                     end
                  end
                  ARG: begin
                     pendStatus <= 1'b0;
                     if (bus.rxData == "1") begin
                        pendRate <= 2'b00;
                        state    <= WAIT_LF;
                     end else if (bus.rxData == "5") begin
                        pendRate <= 2'b01;
                        state    <= WAIT_LF;
                     end else if (bus.rxData == "a") begin
                        pendRate <= 2'b10;
                        state    <= WAIT_LF;
                     end else if (bus.rxData == LF) begin
                        bus.cmdErr <= 1'b1;
                        state      <= IDLE;
                     end else begin
                        state <= DISCARD;
                     end
                  end
                  M_STATE: begin
                     if (bus.rxData == LF) begin
                        bus.cmdErr <= 1'b1;
                        state      <= IDLE;
                        idx        <= 3'd0;
                     end else if (bus.rxData == stateChar(idx)) begin
                        if (idx == 3'd4) begin
                           pendStatus <= 1'b1;
                           state      <= WAIT_LF;
                           idx        <= 3'd0;
                        end else begin
                           idx <= idx + 3'd1;
                        end
                     end else begin
                        state <= DISCARD;
                        idx   <= 3'd0;
                     end
                  end
                  WAIT_LF: begin
                     if (bus.rxData == LF) begin
                        if (pendStatus) begin
                           bus.statusReq <= 1'b1;
                        end else begin
                           bus.rate       <= pendRate;
                           bus.rateUpdate <= 1'b1;
                        end
                        state <= IDLE;
                     end else begin
                        state <= DISCARD;
                     end
                  end
                  DISCARD: begin
                     if (bus.rxData == LF) begin
                        bus.cmdErr <= 1'b1;
                        state      <= IDLE;
                     end
                  end
                  default: begin
                     state <= IDLE;
                     idx   <= 3'd0;
                  end
               endcase
            end
         end else if (state != IDLE) begin
            // A stalled partial line is abandoned; any byte on the expiry cycle wins.
            if (timer == TLIMIT) begin
               state      <= IDLE;
               idx        <= 3'd0;
               pendRate   <= 2'b00;
               pendStatus <= 1'b0;
               timer      <= '0;
               bus.cmdErr <= 1'b1;
            end else begin
               timer <= timer + CW'(1);
            end
         end else begin
            timer <= '0;
         end
      end
   end

endmodule

// File: doc/rx_cmd_decoder.md
# rx_cmd_decoder

Receive-side command decoder for the UART control link. It consumes bytes from the UART receiver and parses lowercase ASCII command lines terminated by LF. Valid commands update the rate selector or request a status report from the transmit-side message generator. It sits between the UART RX byte interface and the rate-control and status-report logic. It is the command input counterpart of the status/rate text the transmit path emits.

## Interface
- TIMEOUT_CYCLES, default 50_000_000: number of clk cycles allowed between bytes of a partial line before the line is aborted.
- clk  input  1  system clock; all logic rising-edge.
- reset  input  1  asynchronous, active-low.
- iRX_DATA  input  8  received byte; sampled only when iRX_VALID=1.
- iRX_VALID  input  1  one-cycle strobe per received byte; may be high on consecutive cycles.
- oRATE  output  2  current rate select: 2'b00 = "1", 2'b01 = "5", 2'b10 = "a"; 2'b11 is never driven.
- oRATE_UPDATE  output  1  one-cycle pulse when oRATE is (re)written by a valid rate command.
- oSTATUS_REQ  output  1  one-cycle pulse on a valid "state" command.
- oCMD_ERR  output  1  one-cycle pulse on a rejected line or a timeout.
- oBUSY  output  1  high while a line is partially received, i.e. state is not IDLE.

## Operation
- Grammar (exact lowercase, no spaces): "rate:" followed by one of '1', '5', 'a', then LF (0x0A). Also "state" then LF.
- CR (0x0D) is ignored in every state.
- FSM states: IDLE, M_RATE, ARG, M_STATE, WAIT_LF, DISCARD.
- A 3-bit match index tracks the position inside the keyword. A pending-command register holds RATE plus argument, or STATUS.
- IDLE:
  - 'r' -> M_RATE, idx=1.
  - 's' -> M_STATE, idx=1.
  - LF -> stays IDLE with no pulse (empty line).
  - Any other byte -> DISCARD.
- M_RATE: expects "ate:" at idx 1..4. A match advances idx; after ':' go to ARG. A mismatch goes to DISCARD.
- ARG:
  - '1' -> pending 2'b00; '5' -> pending 2'b01; 'a' -> pending 2'b10; each then goes to WAIT_LF.
  - Any other byte, including LF, -> DISCARD. An LF here counts as the terminator: pulse oCMD_ERR and go to IDLE.
- M_STATE: expects "tate" at idx 1..4. After the final 'e', pending=STATUS and go to WAIT_LF. A mismatch goes to DISCARD.
- WAIT_LF:
  - LF executes the pending command and returns to IDLE.
  - Any other byte goes to DISCARD.
- Rules that apply in every non-IDLE state:
  - DISCARD swallows bytes until LF. On that LF, pulse oCMD_ERR and go to IDLE.
  - An LF received in M_RATE or M_STATE pulses oCMD_ERR and goes to IDLE.
- Executing RATE: oRATE <= pending and oRATE_UPDATE pulses, even if the value is unchanged.
- Executing STATUS: oSTATUS_REQ pulses; oRATE is untouched.
- Timeout:
  - A counter clears on every iRX_VALID and counts while state is not IDLE.
  - When it reaches TIMEOUT_CYCLES-1: go to IDLE, clear idx and pending, pulse oCMD_ERR.
  - If a byte arrives on the same cycle the count would expire, the byte wins and no timeout occurs.
- Uppercase letters are invalid.

## Timing
- Reset values: oRATE=2'b00, all pulses 0, oBUSY=0, state IDLE, idx=0, timeout counter 0.
- Bytes with iRX_VALID during reset are lost.
- Reset asserted mid-line aborts the line without an error pulse.
- Latency: for the LF sampled at edge N, oRATE, oRATE_UPDATE, oSTATUS_REQ and oCMD_ERR are valid after edge N (registered, 1 cycle). Each pulse is exactly 1 cycle wide.
- At most one of oRATE_UPDATE, oSTATUS_REQ and oCMD_ERR is high in any cycle.
- oBUSY goes high the cycle after the first byte of a line is accepted. It goes low the cycle after the terminating LF or a timeout.
- Back-to-back bytes (iRX_VALID high every cycle) are fully supported; every byte is processed in its own cycle.
- A new line may begin the cycle after LF.
- The timeout counter is wide enough for TIMEOUT_CYCLES and saturates rather than wrapping.

## Test plan
- Reset release, no input -> oRATE=2'b00, oBUSY=0, no pulses for 100 cycles.
- Stream "rate:5\n" back-to-back -> oRATE_UPDATE pulses 1 cycle after LF, oRATE=2'b01. Then "rate:a\r\n" -> oRATE=2'b10; the CR is ignored.
- "state\n" -> single oSTATUS_REQ pulse; oRATE unchanged; oCMD_ERR stays 0.
- Bad lines produce exactly one oCMD_ERR each on their LF, with oRATE unchanged:
  - "rate:7\n"
  - "rAte:1\n"
  - "rate:1x\n"
  - "rate\n"
- With TIMEOUT_CYCLES=16, send "rat" then idle -> oCMD_ERR pulses 16 cycles after the 't'; oBUSY=0. A following "rate:1\n" is accepted with oRATE=2'b00 and an oRATE_UPDATE pulse.
- Assert reset after "rate:" and release, then send "1\n" -> DISCARD path gives oCMD_ERR on the LF; oRATE stays 2'b00 with no update pulse.
